// File: rtl/mycpu_pkg.sv
// Shared CPU datapath types: register/HI-LO write bundles and the GPR address/word types.
package mycpu_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  creg_addr_t;

  localparam int NUM_READ_PORTS = 4;
  localparam int NUM_GPRS       = 32;

  typedef struct packed {
    logic       valid;
    creg_addr_t dst;
    word_t      value;
  } write_reg_t;

  typedef struct packed {
    logic  valid_hi;
    logic  valid_lo;
    word_t hi;
    word_t lo;
  } write_hilo_t;

  // A write only matters for a read when it is valid and targets a real register.
  function automatic logic reg_hit(input write_reg_t w, input creg_addr_t a);
    return w.valid && (w.dst == a) && (a != 5'd0);
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port forwarding: younger write slot beats older slot beats stored value.
module regfile_bypass #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clear_i,
  input  logic        hit1_i,
  input  logic [31:0] val1_i,
  input  logic        hit2_i,
  input  logic [31:0] val2_i,
  input  logic [31:0] stored_i,
  output logic [31:0] data_o
);

  // Select the visible value; clear forces zero so nothing leaks through during reset.
  always_comb begin
    data_o = 32'h0;
    if (clear_i) begin
      data_o = 32'h0;
    end else if (BYPASS && hit2_i) begin
      data_o = val2_i;
    end else if (BYPASS && hit1_i) begin
      data_o = val1_i;
    end else begin
      data_o = stored_i;
    end
  end

endmodule

// File: rtl/regfile_dual.sv
// Dual-issue register file: 31 GPRs plus HI/LO, two write slots, four read ports.
module regfile_dual
  import mycpu_pkg::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  write_reg_t  write_reg_1,
  input  write_reg_t  write_reg_2,
  input  write_hilo_t write_hilo_1,
  input  write_hilo_t write_hilo_2,
  input  logic [4:0]  raddr_1,
  input  logic [4:0]  raddr_2,
  input  logic [4:0]  raddr_3,
  input  logic [4:0]  raddr_4,
  output logic [31:0] rdata_1,
  output logic [31:0] rdata_2,
  output logic [31:0] rdata_3,
  output logic [31:0] rdata_4,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  word_t      gpr_q [1:NUM_GPRS-1];
  word_t      gpr_d [1:NUM_GPRS-1];
  word_t      hi_q;
  word_t      hi_d;
  word_t      lo_q;
  word_t      lo_d;
  logic       clear_s;
  creg_addr_t raddr_s  [NUM_READ_PORTS];
  word_t      stored_s [NUM_READ_PORTS];
  word_t      rdata_s  [NUM_READ_PORTS];
  logic       hit1_s   [NUM_READ_PORTS];
  logic       hit2_s   [NUM_READ_PORTS];

  assign clear_s    = ~resetn;
  assign raddr_s[0] = raddr_1;
  assign raddr_s[1] = raddr_2;
  assign raddr_s[2] = raddr_3;
  assign raddr_s[3] = raddr_4;

  // r0 has no storage, so address 0 falls through the loop and reads as zero.
  function automatic word_t read_gpr(input creg_addr_t a);
    word_t v;
    v = 32'h0;
    for (int i = 1; i < NUM_GPRS; i++) begin
      if (a == 5'(i)) begin
        v = gpr_q[i];
      end
    end
    return v;
  endfunction

  // Next GPR state: slot 2 is younger and overrides slot 1 on a shared destination.
  always_comb begin
    for (int i = 1; i < NUM_GPRS; i++) begin
      gpr_d[i] = gpr_q[i];
      if (reg_hit(write_reg_2, 5'(i))) begin
        gpr_d[i] = write_reg_2.value;
      end else if (reg_hit(write_reg_1, 5'(i))) begin
        gpr_d[i] = write_reg_1.value;
      end else begin
        gpr_d[i] = gpr_q[i];
      end
    end
  end

  // Next HI/LO state, each half resolved independently.
  always_comb begin
    hi_d = write_hilo_2.valid_hi ? write_hilo_2.hi :
           (write_hilo_1.valid_hi ? write_hilo_1.hi : hi_q);
    lo_d = write_hilo_2.valid_lo ? write_hilo_2.lo :
           (write_hilo_1.valid_lo ? write_hilo_1.lo : lo_q);
  end

  // Storage; a write racing an asynchronous reset is simply lost.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 1; i < NUM_GPRS; i++) begin
        gpr_q[i] <= 32'h0;
      end
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      for (int i = 1; i < NUM_GPRS; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_rd
    assign hit1_s[p]   = reg_hit(write_reg_1, raddr_s[p]);
    assign hit2_s[p]   = reg_hit(write_reg_2, raddr_s[p]);
    assign stored_s[p] = read_gpr(raddr_s[p]);

    regfile_bypass #(.BYPASS(BYPASS)) u_byp (
      .clear_i  (clear_s),
      .hit1_i   (hit1_s[p]),
      .val1_i   (write_reg_1.value),
      .hit2_i   (hit2_s[p]),
      .val2_i   (write_reg_2.value),
      .stored_i (stored_s[p]),
      .data_o   (rdata_s[p])
    );
  end

  regfile_bypass #(.BYPASS(BYPASS)) u_hi_byp (
    .clear_i  (clear_s),
    .hit1_i   (write_hilo_1.valid_hi),
    .val1_i   (write_hilo_1.hi),
    .hit2_i   (write_hilo_2.valid_hi),
    .val2_i   (write_hilo_2.hi),
    .stored_i (hi_q),
    .data_o   (hi)
  );

  regfile_bypass #(.BYPASS(BYPASS)) u_lo_byp (
    .clear_i  (clear_s),
    .hit1_i   (write_hilo_1.valid_lo),
    .val1_i   (write_hilo_1.lo),
    .hit2_i   (write_hilo_2.valid_lo),
    .val2_i   (write_hilo_2.lo),
    .stored_i (lo_q),
    .data_o   (lo)
  );

  assign rdata_1 = rdata_s[0];
  assign rdata_2 = rdata_s[1];
  assign rdata_3 = rdata_s[2];
  assign rdata_4 = rdata_s[3];

endmodule
